// File: rtl/xor_descrambler.sv
// Receive-side XOR descrambler: unmasks bytes with a Galois LFSR keystream behind a single output register.
// Optional even-parity output out_par is enabled by defining XOR_DESCRAMBLER_PARITY_EN.
module xor_descrambler #(
    parameter int                 WIDTH     = 8,
    parameter int                 LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]  POLY      = 16'hB400,
    parameter logic [LFSR_W-1:0]  SEED_DFLT = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
`ifdef XOR_DESCRAMBLER_PARITY_EN
    output logic              out_par,
`endif
    output logic [15:0]       byte_cnt,
    output logic              state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
    // out_valid/out_data only change after a transfer or a seed load; in_ready may
    // depend combinationally on out_ready but never on in_valid.

    typedef enum logic {
        LOCKED = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] lfsr;
    logic [WIDTH-1:0]  plain;
    logic              accept;
    logic              drain;

    // Eight unrolled Galois steps: shift right, fold POLY in when the bit shifted out was 1.
    function automatic logic [LFSR_W-1:0] lfsr_adv(input logic [LFSR_W-1:0] l);
        logic [LFSR_W-1:0] r;
        r = l;
        for (int i = 0; i < WIDTH; i++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            LOCKED:  if (seed_load) state_d = RUN;
            RUN:     in_ready = !seed_load && (!out_valid || out_ready);
            default: state_d = LOCKED;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign plain     = in_data ^ lfsr[WIDTH-1:0];
    assign state_dbg = (state_q == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= SEED_DFLT;
            out_valid <= 1'b0;
            out_data  <= '0;
            byte_cnt  <= '0;
        end else if (seed_load) begin
            // A zero seed would lock the LFSR at zero forever.
            lfsr      <= (seed == '0) ? SEED_DFLT : seed;
            out_valid <= 1'b0;
            byte_cnt  <= '0;
        end else if (accept) begin
            out_data  <= plain;
            out_valid <= 1'b1;
            lfsr      <= lfsr_adv(lfsr);
            byte_cnt  <= byte_cnt + 16'd1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

`ifdef XOR_DESCRAMBLER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par <= 1'b0;
        end else if (seed_load) begin
            out_par <= 1'b0;
        end else if (accept) begin
            out_par <= ^plain;
        end
    end
`endif

endmodule

// File: tb/tb_xor_descrambler.sv
// Bench for xor_descrambler: directed seed/byte vectors, stall and reset sequences, and a
// randomized round trip checked against a keystream model built from the LFSR stepping rule.
module tb_xor_descrambler;

    localparam logic [15:0] POLY      = 16'hB400;
    localparam logic [15:0] SEED_DFLT = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [15:0] byte_cnt;
    logic        state_dbg;
`ifdef XOR_DESCRAMBLER_PARITY_EN
    logic        out_par;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [15:0] seed;
        logic [7:0]  data;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vecs[5];

    xor_descrambler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef XOR_DESCRAMBLER_PARITY_EN
        .out_par   (out_par),
`endif
        .byte_cnt  (byte_cnt),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference keystream model ----------------
    function automatic logic [15:0] adv8(input logic [15:0] l);
        logic [15:0] r;
        r = l;
        for (int i = 0; i < 8; i++) begin
            if (r[0]) r = (r >> 1) ^ POLY;
            else      r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] seed_eff(input logic [15:0] s);
        return (s == 16'h0000) ? SEED_DFLT : s;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed_load = 1'b1;
        seed      = s;
        in_valid  = 1'b1;
        #1;
        check("in_ready_during_seed_load", in_ready, 1'b0);
        tick();
        seed_load = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("send_byte_accepted", ok, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        logic [7:0]  plain[256];
        logic [7:0]  masked[257];
        logic [15:0] k;
        logic [7:0]  held;
        logic [7:0]  exp_b;
        int          idx;
        int          got;
        int          cyc;
        bit          acc;
        bit          drn;

        // T1: reset state, and no acceptance without a seed
        rst_n = 1'b0;
        tick();
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 8'h00);
        check("reset_byte_cnt", byte_cnt, 16'h0000);
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_state", state_dbg, 1'b0);
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("locked_in_ready", in_ready, 1'b0);
            check("locked_out_valid", out_valid, 1'b0);
            tick();
        end
        in_valid = 1'b0;

        // Directed first byte after each seed: out = data ^ seed_eff[7:0]
        vecs[0] = '{16'h0001, 8'h5A, 8'h5B};
        vecs[1] = '{16'h0000, 8'h00, 8'hE1};
        vecs[2] = '{16'h1234, 8'h00, 8'h34};
        vecs[3] = '{16'hFFFF, 8'hFF, 8'h00};
        vecs[4] = '{16'h8000, 8'hA5, 8'hA5};
        for (int i = 0; i < 5; i++) begin
            load_seed(vecs[i].seed);
            check("seeded_cnt_zero", byte_cnt, 16'h0000);
            check("seeded_state_run", state_dbg, 1'b1);
            send_byte(vecs[i].data);
            check("vec_out_valid", out_valid, 1'b1);
            check("vec_out_data", out_data, vecs[i].exp_out);
            check("vec_byte_cnt", byte_cnt, 16'h0001);
`ifdef XOR_DESCRAMBLER_PARITY_EN
            check("vec_out_par", out_par, ^vecs[i].exp_out);
`endif
        end

        // T2 second byte: keystream after 8 steps from 0x0001 is 0x0168
        load_seed(16'h0001);
        send_byte(8'h5A);
        send_byte(8'h00);
        check("t2_second_byte", out_data, 8'h68);
        check("t2_second_cnt", byte_cnt, 16'h0002);

        // T5: backpressure holds output, blocks input and does not consume keystream
        load_seed(16'h1234);
        send_byte(8'h00);
        held      = out_data;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_out_data", out_data, held);
            check("stall_byte_cnt", byte_cnt, 16'h0001);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        k = adv8(16'h1234);
        check("after_stall_data", out_data, k[7:0]);
        check("after_stall_cnt", byte_cnt, 16'h0002);

        // T6: reseed discards the pending byte, then asynchronous reset mid-stream
        out_ready = 1'b0;
        check("pre_reseed_valid", out_valid, 1'b1);
        load_seed(16'h5555);
        check("reseed_out_valid", out_valid, 1'b0);
        check("reseed_byte_cnt", byte_cnt, 16'h0000);
        send_byte(8'h00);
        check("reseed_first_data", out_data, 8'h55);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_byte_cnt", byte_cnt, 16'h0000);
        check("async_rst_state", state_dbg, 1'b0);
        check("async_rst_in_ready", in_ready, 1'b0);
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("post_rst_locked", in_ready, 1'b0);
            tick();
        end
        in_valid = 1'b0;

        // T4: randomized round trip with stalls against the keystream model
        k = seed_eff(16'h1234);
        for (int i = 0; i < 256; i++) begin
            plain[i]  = 8'($urandom_range(0, 255));
            masked[i] = plain[i] ^ k[7:0];
            k         = adv8(k);
            exp_q.push_back(plain[i]);
        end
        masked[256] = 8'h00;
        load_seed(16'h1234);
        idx = 0;
        got = 0;
        cyc = 0;
        while (got < 256 && cyc < 5000) begin
            in_valid  = (idx < 256) && ($urandom_range(0, 3) != 0);
            in_data   = masked[idx];
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            check("rt_in_ready_rule", in_ready, !out_valid || out_ready);
            if (drn) begin
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("rt_out_data", out_data, exp_b);
`ifdef XOR_DESCRAMBLER_PARITY_EN
                check("rt_out_par", out_par, ^exp_b);
`endif
                got++;
            end
            if (acc) idx++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rt_bytes_out", got, 256);
        check("rt_bytes_in", idx, 256);
        check("rt_byte_cnt", byte_cnt, 16'd256);
        check("rt_queue_empty", exp_q.size(), 0);
        check("rt_final_valid", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
